// File: rtl/plm_pkg.sv
// -----------------------------------------------------------------------------
// plm_pkg
// Shared definitions for the PLM bank arbiters.
//   - PLM_ADDR_WIDTH / PLM_NBANKS / PLM_NCONSUMERS: default PLM geometry; the
//     arbiter parameters default to these and must agree with them, because
//     the derived widths and the tag type below are built from them.
//   - BANK_SEL_WIDTH: low address bits that select the bank.
//   - LADDR_WIDTH:    in-bank address width.
//   - rd_tag_t:       one stage of the read-tag pipeline {valid, consumer id}.
//   - bank_of():      extracts the bank-select field of a global address.
// -----------------------------------------------------------------------------
package plm_pkg;

    localparam int PLM_ADDR_WIDTH = 4;
    localparam int PLM_NBANKS     = 4;
    localparam int PLM_NCONSUMERS = 8;

    localparam int BANK_SEL_WIDTH = $clog2(PLM_NBANKS);
    localparam int LADDR_WIDTH    = PLM_ADDR_WIDTH - BANK_SEL_WIDTH;
    localparam int ID_WIDTH       = $clog2(PLM_NCONSUMERS);

    typedef struct packed {
        logic                valid;
        logic [ID_WIDTH-1:0] id;
    } rd_tag_t;

    function automatic logic [BANK_SEL_WIDTH-1:0] bank_of(
        input logic [PLM_ADDR_WIDTH-1:0] addr
    );
        return addr[BANK_SEL_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/rr_multi_grant.sv
// -----------------------------------------------------------------------------
// rr_multi_grant
// Combinational multi-grant round-robin scan. Walks the consumers circularly
// starting at the pivot; the k-th eligible consumer found (k < NPORTS) is
// granted on port k. Also produces the next pivot: one past the last granted
// consumer, or the current pivot when nothing is granted.
// Ports:
//   elig_i       [NCONSUMERS]  eligible consumers (valid and bank hit)
//   pivot_i      IDX_W         current scan start
//   grant_idx_o  [NPORTS]      consumer index granted on each port
//   grant_vld_o  [NPORTS]      port k carries a grant
//   pivot_d_o    IDX_W         next pivot value
// -----------------------------------------------------------------------------
module rr_multi_grant #(
    parameter  int NCONSUMERS = 8,
    parameter  int NPORTS     = 2,
    localparam int IDX_W      = $clog2(NCONSUMERS)
) (
    input  logic [NCONSUMERS-1:0] elig_i,
    input  logic [IDX_W-1:0]      pivot_i,
    output logic [IDX_W-1:0]      grant_idx_o [NPORTS],
    output logic [NPORTS-1:0]     grant_vld_o,
    output logic [IDX_W-1:0]      pivot_d_o
);

    int               cnt;
    int               idx;
    logic [IDX_W-1:0] last;

    always_comb begin
        grant_vld_o = '0;
        for (int k = 0; k < NPORTS; k++) grant_idx_o[k] = '0;
        cnt  = 0;
        idx  = 0;
        last = pivot_i;
        for (int j = 0; j < NCONSUMERS; j++) begin
            idx = (int'(pivot_i) + j) % NCONSUMERS;
            if (elig_i[idx]) begin
                // cnt is the number of eligible consumers already seen, so it
                // names the port this one lands on (none once ports run out).
                for (int k = 0; k < NPORTS; k++) begin
                    if (cnt == k) begin
                        grant_idx_o[k] = IDX_W'(idx);
                        grant_vld_o[k] = 1'b1;
                        last           = IDX_W'(idx);
                    end
                end
                cnt++;
            end
        end
        pivot_d_o = (|grant_vld_o) ? IDX_W'((int'(last) + 1) % NCONSUMERS) : pivot_i;
    end

endmodule

// File: rtl/plm_bank_rr_arbiter.sv
// -----------------------------------------------------------------------------
// plm_bank_rr_arbiter
// One instance per PLM bank. Shares the bank's NPORTS physical ports among
// NCONSUMERS requesters with round-robin arbitration, drives registered PLM
// port signals and routes read data back to the issuing consumer through a
// RD_LATENCY-deep tag pipeline per port.
// Ports:
//   clk, reset                clock (rising edge), async active-high reset
//   req_valid/we/addr/wdata   per-consumer request
//   req_ready                 per-consumer grant (combinational)
//   plm_en/we/addr/wdata      registered PLM port drive
//   plm_rdata                 PLM read data, RD_LATENCY cycles after plm_en
//   rsp_valid/rsp_data        per-consumer read response (no backpressure)
//   conflict_cnt              only with PLM_BANK_ARB_STATS_EN: saturating count
//                             of cycles with more eligible consumers than ports
// Build option: define PLM_BANK_ARB_STATS_EN to add conflict_cnt.
// -----------------------------------------------------------------------------
module plm_bank_rr_arbiter
    import plm_pkg::*;
#(
    parameter int ADDR_WIDTH  = PLM_ADDR_WIDTH,
    parameter int VALUE_WIDTH = 8,
    parameter int NCONSUMERS  = PLM_NCONSUMERS,
    parameter int NBANKS      = PLM_NBANKS,
    parameter int NPORTS      = 2,
    parameter int BANK_ID     = 0,
    parameter int RD_LATENCY  = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NCONSUMERS-1:0]  req_valid,
    input  logic [NCONSUMERS-1:0]  req_we,
    input  logic [ADDR_WIDTH-1:0]  req_addr  [NCONSUMERS],
    input  logic [VALUE_WIDTH-1:0] req_wdata [NCONSUMERS],
    output logic [NCONSUMERS-1:0]  req_ready,
    output logic [NPORTS-1:0]      plm_en,
    output logic [NPORTS-1:0]      plm_we,
    output logic [LADDR_WIDTH-1:0] plm_addr  [NPORTS],
    output logic [VALUE_WIDTH-1:0] plm_wdata [NPORTS],
    input  logic [VALUE_WIDTH-1:0] plm_rdata [NPORTS],
    output logic [NCONSUMERS-1:0]  rsp_valid,
    output logic [VALUE_WIDTH-1:0] rsp_data  [NCONSUMERS]
`ifdef PLM_BANK_ARB_STATS_EN
    ,
    output logic [15:0]            conflict_cnt
`endif
);

    localparam int IDX_W = $clog2(NCONSUMERS);
    localparam int SEL_W = $clog2(NBANKS);

    logic [NCONSUMERS-1:0]  elig;
    logic [IDX_W-1:0]       grant_idx [NPORTS];
    logic [NPORTS-1:0]      grant_vld;
    logic [IDX_W-1:0]       pivot_d;
    logic [IDX_W-1:0]       pivot_q;

    logic [NPORTS-1:0]      en_q;
    logic [NPORTS-1:0]      we_q;
    logic [LADDR_WIDTH-1:0] addr_q  [NPORTS];
    logic [VALUE_WIDTH-1:0] wdata_q [NPORTS];
    logic [IDX_W-1:0]       id_q    [NPORTS];
    rd_tag_t                tag_q   [NPORTS][RD_LATENCY];

    always_comb begin
        for (int i = 0; i < NCONSUMERS; i++)
            elig[i] = req_valid[i] && (bank_of(req_addr[i]) == SEL_W'(BANK_ID));
    end

    rr_multi_grant #(
        .NCONSUMERS (NCONSUMERS),
        .NPORTS     (NPORTS)
    ) u_grant (
        .elig_i      (elig),
        .pivot_i     (pivot_q),
        .grant_idx_o (grant_idx),
        .grant_vld_o (grant_vld),
        .pivot_d_o   (pivot_d)
    );

    // Each consumer appears on at most one port, so no two ports collide here.
    always_comb begin
        req_ready = '0;
        for (int k = 0; k < NPORTS; k++)
            if (grant_vld[k]) req_ready[grant_idx[k]] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pivot_q <= '0;
            en_q    <= '0;
            we_q    <= '0;
            for (int k = 0; k < NPORTS; k++) begin
                addr_q[k]  <= '0;
                wdata_q[k] <= '0;
                id_q[k]    <= '0;
                for (int s = 0; s < RD_LATENCY; s++) tag_q[k][s] <= '0;
            end
        end else begin
            pivot_q <= pivot_d;
            for (int k = 0; k < NPORTS; k++) begin
                en_q[k] <= grant_vld[k];
                // Idle ports keep their last address/data to avoid needless toggling.
                if (grant_vld[k]) begin
                    we_q[k]    <= req_we[grant_idx[k]];
                    addr_q[k]  <= req_addr[grant_idx[k]][SEL_W +: LADDR_WIDTH];
                    wdata_q[k] <= req_wdata[grant_idx[k]];
                    id_q[k]    <= grant_idx[k];
                end
                // Tag enters while the PLM sees the access, so it leaves the
                // last stage in the cycle the PLM presents the read data.
                tag_q[k][0] <= '{valid: en_q[k] && !we_q[k], id: id_q[k]};
                for (int s = 1; s < RD_LATENCY; s++) tag_q[k][s] <= tag_q[k][s-1];
            end
        end
    end

    assign plm_en    = en_q;
    assign plm_we    = we_q;
    assign plm_addr  = addr_q;
    assign plm_wdata = wdata_q;

    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NCONSUMERS; i++) rsp_data[i] = '0;
        for (int k = 0; k < NPORTS; k++) begin
            if (tag_q[k][RD_LATENCY-1].valid) begin
                rsp_valid[tag_q[k][RD_LATENCY-1].id] = 1'b1;
                rsp_data[tag_q[k][RD_LATENCY-1].id]  = plm_rdata[k];
            end
        end
    end

`ifdef PLM_BANK_ARB_STATS_EN
    logic [15:0] conflict_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            conflict_q <= '0;
        else if (($countones(elig) > NPORTS) && (conflict_q != 16'hFFFF))
            conflict_q <= conflict_q + 16'd1;
    end

    assign conflict_cnt = conflict_q;
`endif

endmodule

// File: tb/tb_plm_bank_rr_arbiter.sv
module tb_plm_bank_rr_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] req_valid = '0;
    logic [7:0] req_we = '0;
    logic [3:0] req_addr  [8];
    logic [7:0] req_wdata [8];
    logic [7:0] req_ready;
    logic [1:0] plm_en;
    logic [1:0] plm_we;
    logic [1:0] plm_addr  [2];
    logic [7:0] plm_wdata [2];
    logic [7:0] plm_rdata [2];
    logic [7:0] rsp_valid;
    logic [7:0] rsp_data  [8];
`ifdef PLM_BANK_ARB_STATS_EN
    logic [15:0] conflict_cnt;
`endif

    plm_bank_rr_arbiter #(
        .ADDR_WIDTH(4), .VALUE_WIDTH(8), .NCONSUMERS(8), .NBANKS(4),
        .NPORTS(2), .BANK_ID(1), .RD_LATENCY(1)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_ready(req_ready),
        .plm_en(plm_en), .plm_we(plm_we), .plm_addr(plm_addr),
        .plm_wdata(plm_wdata), .plm_rdata(plm_rdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data)
`ifdef PLM_BANK_ARB_STATS_EN
        , .conflict_cnt(conflict_cnt)
`endif
    );

    always #5 clk = ~clk;

    // PLM bank model: one-cycle registered read.
    logic [7:0] mem [4];
    initial begin
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h3C; mem[3] = 8'h44;
        plm_rdata[0] = '0; plm_rdata[1] = '0;
        for (int i = 0; i < 8; i++) begin req_addr[i] = '0; req_wdata[i] = '0; end
    end
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (plm_en[k]) begin
                if (plm_we[k]) mem[plm_addr[k]] <= plm_wdata[k];
                else           plm_rdata[k]     <= mem[plm_addr[k]];
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    typedef struct {
        int         due;
        int         port;
        logic       we;
        logic [1:0] addr;
        logic [7:0] wdata;
    } pev_t;

    typedef struct {
        int         due;
        int         id;
        logic [7:0] data;
    } rev_t;

    pev_t pq[$];
    rev_t rq[$];

    // Expect consumer id on port k next cycle; reads also expect rd_data back
    // two cycles after the handshake when with_rsp is set.
    task automatic exp_port(input int k, input int id, input logic [7:0] rd_data, input bit with_rsp);
        pev_t p;
        rev_t r;
        p.due = cyc + 1; p.port = k; p.we = req_we[id];
        p.addr = req_addr[id][3:2]; p.wdata = req_wdata[id];
        pq.push_back(p);
        if (!req_we[id] && with_rsp) begin
            r.due = cyc + 2; r.id = id; r.data = rd_data;
            rq.push_back(r);
        end
    endtask

    // Monitor: compares every cycle's port activity and responses against
    // whatever the stimulus queued for that cycle.
    pev_t       mp;
    rev_t       mr;
    logic [1:0] emask;
    logic [7:0] rmask;
    always @(negedge clk) begin
        emask = '0;
        rmask = '0;
        while (pq.size() > 0 && pq[0].due <= cyc) begin
            mp = pq.pop_front();
            if (mp.due < cyc) check("port_event_missed", 32'(mp.due), 32'(cyc));
            else begin
                emask[mp.port] = 1'b1;
                check("plm_port_fields", {21'd0, plm_we[mp.port], plm_addr[mp.port], plm_wdata[mp.port]},
                      {21'd0, mp.we, mp.addr, mp.wdata});
            end
        end
        check("plm_en", {30'd0, plm_en}, {30'd0, emask});
        while (rq.size() > 0 && rq[0].due <= cyc) begin
            mr = rq.pop_front();
            if (mr.due < cyc) check("rsp_event_missed", 32'(mr.due), 32'(cyc));
            else begin
                rmask[mr.id] = 1'b1;
                check("rsp_data", {24'd0, rsp_data[mr.id]}, {24'd0, mr.data});
            end
        end
        check("rsp_valid", {24'd0, rsp_valid}, {24'd0, rmask});
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int id, input logic we, input logic [3:0] addr, input logic [7:0] wd);
        req_valid[id] = 1'b1; req_we[id] = we; req_addr[id] = addr; req_wdata[id] = wd;
    endtask

    task automatic clear_req();
        req_valid = '0; req_we = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #5 reset = 1'b1;
        #7;
        check("rst_plm_en", {30'd0, plm_en}, 32'd0);
        check("rst_rsp_valid", {24'd0, rsp_valid}, 32'd0);
        check("rst_pivot", {29'd0, dut.pivot_q}, 32'd0);
        check("rst_port_regs", {10'd0, plm_we, plm_addr[0], plm_addr[1], plm_wdata[0], plm_wdata[1]}, 32'd0);
        #5 reset = 1'b0;

        // Four readers on bank 1, two ports: round robin must alternate.
        next();
        set_req(0, 1'b0, 4'h1, 8'h00);
        set_req(2, 1'b0, 4'hD, 8'h00);
        set_req(4, 1'b0, 4'h1, 8'h00);
        set_req(6, 1'b0, 4'hD, 8'h00);
        #1;
        check("rr1_ready", {24'd0, req_ready}, 32'h05);
        exp_port(0, 0, 8'h11, 1); exp_port(1, 2, 8'h44, 1);
        next();
        check("rr2_ready", {24'd0, req_ready}, 32'h50);
        exp_port(0, 4, 8'h11, 1); exp_port(1, 6, 8'h44, 1);
        next();
        check("rr3_ready", {24'd0, req_ready}, 32'h05);
        exp_port(0, 0, 8'h11, 1); exp_port(1, 2, 8'h44, 1);
        next();
        clear_req();
        check("pivot_after_rr", {29'd0, dut.pivot_q}, 32'd3);

        // Write from consumer 3: in-bank address 1, no response.
        next();
        set_req(3, 1'b1, 4'h5, 8'hA5);
        #1;
        check("wr_ready", {24'd0, req_ready}, 32'h08);
        exp_port(0, 3, 8'h00, 1);
        next();
        clear_req();

        // Read from consumer 5 at in-bank address 2.
        next();
        set_req(5, 1'b0, 4'h9, 8'h00);
        #1;
        check("rd5_ready", {24'd0, req_ready}, 32'h20);
        exp_port(0, 5, 8'h3C, 1);
        next();
        clear_req();

        // Consumer 7 targets bank 2: never granted here.
        next();
        set_req(7, 1'b0, 4'h2, 8'h00);
        #1;
        check("wrong_bank_ready", {24'd0, req_ready}, 32'h00);
        next();
        check("wrong_bank_ready2", {24'd0, req_ready}, 32'h00);
        check("pivot_unchanged", {29'd0, dut.pivot_q}, 32'd6);
        clear_req();

        // Read accepted, then reset while it is in flight: no response.
        next();
        set_req(4, 1'b0, 4'h1, 8'h00);
        #1;
        check("inflight_ready", {24'd0, req_ready}, 32'h10);
        exp_port(0, 4, 8'h00, 0);
        next();
        clear_req();
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check("midrst_plm_en", {30'd0, plm_en}, 32'd0);
        check("midrst_pivot", {29'd0, dut.pivot_q}, 32'd0);
        next();
        next();
        reset = 1'b0;
        check("postrst_pivot", {29'd0, dut.pivot_q}, 32'd0);

        // Scan must restart at consumer 0: 1 on port 0, 6 on port 1.
        set_req(1, 1'b0, 4'hD, 8'h00);
        set_req(6, 1'b0, 4'h1, 8'h00);
        #1;
        check("postrst_ready", {24'd0, req_ready}, 32'h42);
        exp_port(0, 1, 8'h44, 1); exp_port(1, 6, 8'h11, 1);
        next();
        clear_req();

        repeat (4) next();
        check("queues_drained", 32'(pq.size() + rq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/plm_bank_rr_arbiter.md
Name: plm_bank_rr_arbiter

Overview:
- One instance per PLM bank. Shares that bank's NPORTS physical ports among NCONSUMERS requesters using round-robin arbitration.
- Filters requests by bank-select bits and grants at most NPORTS requests per cycle over a valid/ready handshake.
- Drives registered PLM port signals.
- Tracks in-flight reads with a tag pipeline so read data returns to the consumer that issued the read.

Parameters:
- ADDR_WIDTH, 4: global word address width; low $clog2(NBANKS) bits select the bank.
- VALUE_WIDTH, 8: data width.
- NCONSUMERS, 8: number of requesters.
- NBANKS, 4: number of banks in the PLM; power of two, at least 2.
- NPORTS, 2: physical ports on this bank.
- BANK_ID, 0: index of the bank this instance serves.
- RD_LATENCY, 1: PLM read latency in cycles, from plm_en to valid plm_rdata; at least 1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  [NCONSUMERS]x1  request valid.
- req_we  in  [NCONSUMERS]x1  1 = write, 0 = read.
- req_addr  in  [NCONSUMERS]xADDR_WIDTH  global address.
- req_wdata  in  [NCONSUMERS]xVALUE_WIDTH  write data.
- req_ready  out  [NCONSUMERS]x1  grant; combinational.
- plm_en  out  [NPORTS]x1  port access strobe.
- plm_we  out  [NPORTS]x1  port write enable.
- plm_addr  out  [NPORTS]xLADDR_WIDTH  in-bank address; LADDR_WIDTH = ADDR_WIDTH - $clog2(NBANKS).
- plm_wdata  out  [NPORTS]xVALUE_WIDTH  port write data.
- plm_rdata  in  [NPORTS]xVALUE_WIDTH  port read data.
- rsp_valid  out  [NCONSUMERS]x1  read response valid.
- rsp_data  out  [NCONSUMERS]xVALUE_WIDTH  read response data.

Behaviour:
- Eligibility: consumer i is eligible when req_valid[i] is high and req_addr[i][$clog2(NBANKS)-1:0] == BANK_ID.
- Arbitration (combinational):
  - Scan consumers circularly starting at pivot.
  - The k-th eligible consumer found, for k < NPORTS, is granted on port k.
  - req_ready[i] = 1 only for granted consumers; a transfer occurs when valid && ready.
  - Eligible consumers not granted see ready = 0 and must hold their request.
- Pivot register, width $clog2(NCONSUMERS), reset value 0:
  - If any grant: pivot <= (last granted index + 1) mod NCONSUMERS.
  - Otherwise pivot is unchanged.
  - Wrap-around: a grant to consumer NCONSUMERS-1 sets pivot to 0.
- Port registers, updated one cycle after grant:
  - plm_en[k] <= 1 if port k was granted, else 0.
  - plm_we, plm_addr (req_addr[LSB+:LADDR_WIDTH], the upper bits) and plm_wdata are captured from the granted consumer.
  - Unused ports drive plm_en = 0; plm_we, plm_addr and plm_wdata hold their last values.
- Read tag pipeline: per port, a RD_LATENCY-deep shift register of {valid, consumer_id}.
  - Pushed with valid = plm_en && !plm_we.
  - On emerge: rsp_valid[id] = 1 and rsp_data[id] = plm_rdata[k] in the same cycle (combinational from the stage output).
- Latency: handshake at cycle T; plm_en at T+1; rsp_valid at T+1+RD_LATENCY. Writes produce no response.
- Throughput: a consumer may be granted every cycle and may have up to RD_LATENCY+1 reads outstanding; responses return in order.
- Response collisions are impossible: each consumer is granted at most once per cycle, and all ports share the same latency.
- No response backpressure: consumers must accept rsp_valid unconditionally.
- Reset (async, any time):
  - pivot = 0; all plm_en = 0; plm_we = 0; plm_addr = 0; plm_wdata = 0.
  - All tag-pipeline valid bits = 0, so rsp_valid = 0. In-flight reads are dropped with no response.
  - req_ready is still computed combinationally from inputs while reset is high.

Optional Feature:
- Macro: PLM_BANK_ARB_STATS_EN.
- When defined:
  - Adds output port conflict_cnt (16 bits, reset 0).
  - Increments by 1 in every cycle where the number of eligible consumers exceeds NPORTS.
  - Saturates at 16'hFFFF.
- When undefined: the port and the counter logic are absent. Arbitration is identical in both builds.

Decomposition:
- Package plm_pkg holds:
  - localparams LADDR_WIDTH and BANK_SEL_WIDTH.
  - typedef rd_tag_t, a struct {logic valid; logic [$clog2(NCONSUMERS)-1:0] id;}.
  - function bank_of(addr).
- One sub-module, rr_multi_grant: the combinational circular scan from pivot, producing per-port grant index and valid, plus the next pivot.
- The tag pipeline stays inline.

Test Plan (NCONSUMERS=8, NBANKS=4, NPORTS=2, BANK_ID=1, RD_LATENCY=1, VALUE_WIDTH=8):
- Reset pulse in the 5 to 20 ns window, no requests -> all plm_en = 0, rsp_valid = 0, pivot = 0.
- Consumer 3 writes addr 4'h5 (bank 1), data 8'hA5 -> req_ready[3] = 1 the same cycle; next cycle plm_en[0] = 1, plm_we[0] = 1, plm_addr[0] = 2'h1, plm_wdata[0] = 8'hA5; no rsp_valid.
- Consumers 0, 2, 4 and 6 all hold reads to bank 1 -> cycle 1 grants {0, 2}, cycle 2 grants {4, 6}, cycle 3 grants {0, 2}; no consumer starves.
- Consumer 5 reads addr 4'h9 while the PLM model returns 8'h3C -> rsp_valid[5] = 1 with rsp_data[5] = 8'h3C exactly 2 cycles after the handshake; no other rsp_valid is asserted.
- Consumer 7 requests addr 4'h2 (bank 2) -> req_ready[7] = 0 and plm_en stays 0.
- Read accepted, then reset asserted 1 cycle later -> rsp_valid never rises; after release, pivot = 0 and the next grant starts its scan from consumer 0.
